// File: rtl/alu_bist_engine.sv
// Logic BIST engine: an LFSR drives a WIDTH-bit ALU and a MISR compacts the results.
// The final signature is checked against a golden value, or the run always passes in capture mode.
module alu_bist_engine #(
    parameter int unsigned      WIDTH        = 8,
    parameter int unsigned      NUM_PATTERNS = 256,
    parameter int unsigned      LW           = 2*WIDTH+3,
    parameter logic [LW-1:0]    LFSR_SEED    = LW'(1),
    parameter logic [LW-1:0]    LFSR_TAPS    = LW'('h2B5),
    parameter logic [WIDTH-1:0] MISR_POLY    = WIDTH'('h1D)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                bist_start,
    input  logic                                mode,
    input  logic [WIDTH-1:0]                    golden_sig,
    input  logic                                fault_en,
    input  logic [$clog2(WIDTH)-1:0]            fault_bit,
    output logic                                bist_busy,
    output logic                                bist_done,
    output logic                                bist_pass,
    output logic                                bist_fail,
    output logic [WIDTH-1:0]                    signature,
    output logic [$clog2(NUM_PATTERNS+1)-1:0]   pattern_count
);

    localparam int unsigned CW = $clog2(NUM_PATTERNS+1);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [LW-1:0] SEED_EFF = (LFSR_SEED == '0) ? LW'(1) : LFSR_SEED;
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_PATTERNS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        RUN     = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     lfsr_q, lfsr_d;
    logic [WIDTH-1:0]  misr_q, misr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              mode_q, mode_d;
    logic [WIDTH-1:0]  golden_q, golden_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [2:0]        opcode;
    logic [WIDTH-1:0]  op_a, op_b;
    logic [WIDTH-1:0]  alu_res, fault_mask, result;
    logic [WIDTH-1:0]  misr_next;
    logic [LW-1:0]     lfsr_next;
    logic              verdict;

    assign opcode = lfsr_q[2:0];
    assign op_b   = lfsr_q[WIDTH+2:3];
    assign op_a   = lfsr_q[2*WIDTH+2:WIDTH+3];

    // Datapath ALU under test
    always_comb begin
        alu_res = '0;
        case (opcode)
            3'd0:    alu_res = op_a + op_b;
            3'd1:    alu_res = op_a - op_b;
            3'd2:    alu_res = op_a & op_b;
            3'd3:    alu_res = op_a | op_b;
            3'd4:    alu_res = op_a ^ op_b;
            3'd5:    alu_res = {op_a[WIDTH-2:0], 1'b0};
            3'd6:    alu_res = {1'b0, op_a[WIDTH-1:1]};
            default: alu_res = ~op_a;
        endcase
    end

    assign fault_mask = WIDTH'(fault_en) << fault_bit;
    assign result     = alu_res ^ fault_mask;

    assign misr_next = {misr_q[WIDTH-2:0], 1'b0}
                     ^ (misr_q[WIDTH-1] ? MISR_POLY : '0)
                     ^ result;
    assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    assign verdict   = mode_q | (misr_q == golden_q);

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        misr_d   = misr_q;
        count_d  = count_q;
        mode_d   = mode_q;
        golden_d = golden_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        case (state_q)
            IDLE, DONE: begin
                if (bist_start) begin
                    state_d  = INIT;
                    lfsr_d   = SEED_EFF;
                    misr_d   = '0;
                    count_d  = '0;
                    pass_d   = 1'b0;
                    fail_d   = 1'b0;
                    mode_d   = mode;
                    golden_d = golden_sig;
                end
            end
            INIT: begin
                state_d = RUN;
            end
            RUN: begin
                misr_d  = misr_next;
                lfsr_d  = lfsr_next;
                count_d = count_q + CW'(1);
                if (count_q == LAST_CNT) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                pass_d  = verdict;
                fail_d  = ~verdict;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == INIT) || (state_d == RUN) || (state_d == COMPARE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lfsr_q   <= '0;
            misr_q   <= '0;
            count_q  <= '0;
            mode_q   <= 1'b0;
            golden_q <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            misr_q   <= misr_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            golden_q <= golden_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bist_busy     = busy_q;
    assign bist_done     = done_q;
    assign bist_pass     = pass_q;
    assign bist_fail     = fail_q;
    assign signature     = misr_q;
    assign pattern_count = count_q;

endmodule

// File: tb/tb_alu_bist_engine.sv
// Directed bench for alu_bist_engine: default 8-bit engine plus a 4-bit single-pattern engine.
module tb_alu_bist_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       m_start, m_mode, m_fen;
    logic [7:0] m_golden;
    logic [2:0] m_fbit;
    logic       m_busy, m_done, m_pass, m_fail;
    logic [7:0] m_sig;
    logic [8:0] m_cnt;

    logic       s_start, s_mode, s_fen;
    logic [3:0] s_golden;
    logic [1:0] s_fbit;
    logic       s_busy, s_done, s_pass, s_fail;
    logic [3:0] s_sig;
    logic [0:0] s_cnt;

    alu_bist_engine u_dut (
        .clk(clk), .reset(reset), .bist_start(m_start), .mode(m_mode),
        .golden_sig(m_golden), .fault_en(m_fen), .fault_bit(m_fbit),
        .bist_busy(m_busy), .bist_done(m_done), .bist_pass(m_pass),
        .bist_fail(m_fail), .signature(m_sig), .pattern_count(m_cnt)
    );

    alu_bist_engine #(.WIDTH(4), .NUM_PATTERNS(1), .LFSR_SEED(11'h008)) u_small (
        .clk(clk), .reset(reset), .bist_start(s_start), .mode(s_mode),
        .golden_sig(s_golden), .fault_en(s_fen), .fault_bit(s_fbit),
        .bist_busy(s_busy), .bist_done(s_done), .bist_pass(s_pass),
        .bist_fail(s_fail), .signature(s_sig), .pattern_count(s_cnt)
    );

    int checks = 0;
    int failures = 0;
    logic [18:0] lfsr_m;
    logic [7:0]  misr_m;
    logic [7:0]  sig_s;
    // Signatures after patterns 1..4 from seed 1, worked out by hand
    logic [7:0]  hand_sig [4] = '{8'h00, 8'h00, 8'hFF, 8'hE3};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [2:0] op;
        logic [7:0] a, b, r;
        op = lfsr_m[2:0];
        b  = lfsr_m[10:3];
        a  = lfsr_m[18:11];
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << 1;
            3'd6: r = a >> 1;
            default: r = ~a;
        endcase
        misr_m = {misr_m[6:0], 1'b0} ^ (misr_m[7] ? 8'h1D : 8'h00) ^ r;
        lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 19'h002B5 : 19'h00000);
    endtask

    task automatic chk_main_idle(input string tag);
        chk({tag, "_busy"}, 32'(m_busy), 32'd0);
        chk({tag, "_done"}, 32'(m_done), 32'd0);
        chk({tag, "_pass"}, 32'(m_pass), 32'd0);
        chk({tag, "_fail"}, 32'(m_fail), 32'd0);
        chk({tag, "_sig"},  32'(m_sig),  32'd0);
        chk({tag, "_cnt"},  32'(m_cnt),  32'd0);
    endtask

    task automatic main_run(input logic md, input logic [7:0] gold, input int pulse_at, input logic hold);
        logic exp_pass;
        m_mode = md; m_golden = gold; m_start = 1'b1;
        step();
        chk("e0_busy", 32'(m_busy), 32'd1);
        chk("e0_done", 32'(m_done), 32'd0);
        chk("e0_pass", 32'(m_pass), 32'd0);
        chk("e0_fail", 32'(m_fail), 32'd0);
        chk("e0_cnt",  32'(m_cnt),  32'd0);
        m_start = hold;
        m_mode = ~md; m_golden = ~gold;
        step();
        chk("e1_busy", 32'(m_busy), 32'd1);
        chk("e1_sig",  32'(m_sig),  32'd0);
        lfsr_m = 19'd1;
        misr_m = 8'h00;
        for (int i = 1; i <= 256; i++) begin
            m_start = (i == pulse_at) ? 1'b1 : hold;
            model_step();
            step();
            chk("run_sig",  32'(m_sig),  32'(misr_m));
            chk("run_cnt",  32'(m_cnt),  32'(i));
            chk("run_busy", 32'(m_busy), 32'd1);
            chk("run_done", 32'(m_done), 32'd0);
            if (i <= 4) chk("hand_sig", 32'(m_sig), 32'(hand_sig[i-1]));
        end
        m_start = hold;
        step();
        exp_pass = md | (misr_m == gold);
        chk("end_done", 32'(m_done), 32'd1);
        chk("end_busy", 32'(m_busy), 32'd0);
        chk("end_pass", 32'(m_pass), 32'(exp_pass));
        chk("end_fail", 32'(m_fail), 32'(!exp_pass));
        chk("end_sig",  32'(m_sig),  32'(misr_m));
        chk("end_cnt",  32'(m_cnt),  32'd256);
    endtask

    task automatic small_run(input logic [3:0] gold, input logic fen, input logic [1:0] fbit,
                             input logic [3:0] exp_sig, input logic exp_pass);
        s_mode = 1'b0; s_golden = gold; s_fen = fen; s_fbit = fbit; s_start = 1'b1;
        step();
        chk("s_e0_busy", 32'(s_busy), 32'd1);
        chk("s_e0_done", 32'(s_done), 32'd0);
        s_start = 1'b0;
        step();
        chk("s_e1_sig", 32'(s_sig), 32'd0);
        chk("s_e1_cnt", 32'(s_cnt), 32'd0);
        step();
        chk("s_run_sig",  32'(s_sig),  32'(exp_sig));
        chk("s_run_cnt",  32'(s_cnt),  32'd1);
        chk("s_run_done", 32'(s_done), 32'd0);
        step();
        chk("s_end_done", 32'(s_done), 32'd1);
        chk("s_end_busy", 32'(s_busy), 32'd0);
        chk("s_end_pass", 32'(s_pass), 32'(exp_pass));
        chk("s_end_fail", 32'(s_fail), 32'(!exp_pass));
        chk("s_end_sig",  32'(s_sig),  32'(exp_sig));
    endtask

    initial begin
        reset = 1'b1;
        m_start = 1'b0; m_mode = 1'b0; m_golden = 8'h00; m_fen = 1'b0; m_fbit = 3'd0;
        s_start = 1'b0; s_mode = 1'b0; s_golden = 4'h0; s_fen = 1'b0; s_fbit = 2'd0;
        step();
        step();
        chk_main_idle("rst");
        chk("rst_s_busy", 32'(s_busy), 32'd0);
        chk("rst_s_done", 32'(s_done), 32'd0);
        chk("rst_s_sig",  32'(s_sig),  32'd0);
        reset = 1'b0;
        step();
        chk_main_idle("idle");

        // Capture run, then compare against the captured signature
        main_run(1'b1, 8'h00, 0, 1'b0);
        sig_s = misr_m;
        main_run(1'b0, sig_s, 0, 1'b0);
        chk("cmp_sig", 32'(m_sig), 32'(sig_s));

        // Wrong golden value
        main_run(1'b0, sig_s ^ 8'h01, 0, 1'b0);
        chk("wrong_sig", 32'(m_sig), 32'(sig_s));

        // Reset at pattern 100
        m_mode = 1'b1; m_start = 1'b1;
        step();
        m_start = 1'b0;
        step();
        lfsr_m = 19'd1;
        misr_m = 8'h00;
        for (int i = 1; i <= 100; i++) begin
            model_step();
            step();
        end
        chk("mid_cnt", 32'(m_cnt), 32'd100);
        chk("mid_sig", 32'(m_sig), 32'(misr_m));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_main_idle("midrst");
        step();
        chk_main_idle("midrst_hold");
        main_run(1'b1, 8'h00, 0, 1'b0);
        chk("after_rst_sig", 32'(m_sig), 32'(sig_s));

        // Start pulse during RUN is ignored
        main_run(1'b0, sig_s, 50, 1'b0);

        // Start held high: back-to-back runs
        main_run(1'b0, sig_s, 0, 1'b1);
        chk("held1_sig", 32'(m_sig), 32'(sig_s));
        main_run(1'b0, sig_s, 0, 1'b1);
        chk("held2_sig", 32'(m_sig), 32'(sig_s));
        m_start = 1'b0;
        step();
        chk("done_hold", 32'(m_done), 32'd1);
        chk("done_hold_pass", 32'(m_pass), 32'd1);

        // 4-bit engine: ADD 0+1 with and without an injected fault
        small_run(4'h1, 1'b0, 2'd0, 4'h1, 1'b1);
        small_run(4'h1, 1'b1, 2'd3, 4'h9, 1'b0);
        small_run(4'h0, 1'b1, 2'd0, 4'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_bist_engine.md
# alu_bist_engine

Parametrised, self-contained logic BIST engine for the datapath ALU, and the successor to the fixed-width ALU BIST top.
- An LFSR pattern generator drives an internal WIDTH-bit ALU. A MISR compacts the results.
- The final signature is either compared against a supplied golden value or reported for golden capture.
- Adds width, pattern-count and polynomial generics, a capture mode and a result fault-injection hook.
- Sits under the SoC test controller, which pulses bist_start and reads done, pass, fail and signature.

## Interface
- WIDTH, 8: ALU operand/result width, ≥4.
- NUM_PATTERNS, 256: patterns applied per run, ≥1.
- LW, 2*WIDTH+3: LFSR width (derived; do not override).
- LFSR_SEED, 1: LW-bit start state; an all-zero value is replaced by 1.
- LFSR_TAPS, {LW{1'b0}} | 'h2B5: Galois tap mask, LW bits.
- MISR_POLY, 'h1D: WIDTH-bit MISR feedback mask.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high; returns to IDLE.
- bist_start  in  1  level sampled each edge; acted on only in IDLE or DONE.
- mode  in  1  0 = compare against golden_sig, 1 = capture (always pass). Sampled with bist_start.
- golden_sig  in  WIDTH  expected signature, sampled with bist_start.
- fault_en  in  1  when 1, bit fault_bit of every ALU result is inverted.
- fault_bit  in  $clog2(WIDTH)  index of the bit to invert.
- bist_busy  out  1  high in INIT, RUN and COMPARE.
- bist_done  out  1  high in DONE.
- bist_pass  out  1  verdict, valid while bist_done is high.
- bist_fail  out  1  verdict, valid while bist_done is high.
- signature  out  WIDTH  live MISR contents, held after the run.
- pattern_count  out  $clog2(NUM_PATTERNS+1)  patterns applied so far.

## Operation
- FSM states: IDLE → INIT → RUN → COMPARE → DONE.
  - DONE → INIT when bist_start=1; DONE holds otherwise.
  - bist_start is ignored in INIT, RUN and COMPARE.
- IDLE: waits for bist_start.
- INIT:
  - lfsr ← LFSR_SEED, or 1 if the seed is 0.
  - misr ← 0, count ← 0, pass/fail ← 0.
  - The sampled mode and golden_sig are latched.
- LFSR field decode:
  - op = lfsr[2:0]
  - B = lfsr[WIDTH+2:3]
  - A = lfsr[2*WIDTH+2:WIDTH+3]
- ALU operations, result truncated to WIDTH:
  - 0 A+B
  - 1 A−B
  - 2 A&B
  - 3 A|B
  - 4 A^B
  - 5 A<<1
  - 6 A>>1 (logical)
  - 7 ~A
- Fault injection: r = alu ^ (fault_en << fault_bit), evaluated combinationally each RUN cycle.
- Each RUN cycle:
  - misr ← {misr[WIDTH-2:0],1'b0} ^ (misr[WIDTH-1] ? MISR_POLY : 0) ^ r.
  - lfsr ← (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0).
  - count ← count+1.
  - The FSM leaves RUN on the edge where count reaches NUM_PATTERNS.
- COMPARE verdict:
  - mode=1: pass.
  - mode=0: pass iff misr == golden_sig.
  - fail = ~pass, registered on the edge into DONE.
- DONE: exactly one of pass/fail is high; signature and pattern_count are held.

## Timing
- Reset values: busy=0, done=0, pass=0, fail=0, signature=0, pattern_count=0, state IDLE.
- bist_start is sampled in IDLE/DONE at edge E0. Then:
  - busy rises after E0.
  - The first pattern is applied in the cycle after E1.
  - done, pass and fail are valid after edge E0+NUM_PATTERNS+2.
  - busy falls on that same edge.
- pass/fail are 0 whenever done=0. done stays high until a new start or reset.
- Reset asserted mid-run: the next edge forces IDLE with all outputs at their reset values. No partial verdict is produced.
- Restart from DONE: done, pass and fail drop on the edge after start is sampled. Signature and pattern_count clear in INIT.
- bist_start held high: one run, then an immediate rerun from DONE.
- fault_en and fault_bit may change mid-run and take effect in the same cycle.

## Test plan
- Capture then compare, WIDTH=8 and NUM_PATTERNS=256:
  - Run with mode=1 → pass=1, signature=S.
  - Rerun with mode=0, golden_sig=S → pass=1, fail=0, done after exactly 258 edges, pattern_count=256.
- WIDTH=4, NUM_PATTERNS=1, LFSR_SEED=11'h008 (ADD 0+1):
  - mode=0, golden_sig=4'h1 → pass, signature=4'h1.
  - With fault_en=1, fault_bit=3 → signature=4'h9, fail=1.
- Wrong golden: default params, golden_sig=S^1, mode=0 → fail=1, pass=0, done=1, signature=S.
- Reset mid-run: assert reset at pattern 100 for 1 cycle → next cycle all outputs 0, state IDLE. A new start then yields signature S again.
- Start during RUN: pulse bist_start at pattern 50 → ignored, done timing unchanged at 258 edges.
- Start held high through DONE → second run starts immediately and produces an identical S. The bench model checks the LFSR/MISR sequence against the RTL every cycle.
